bus_dest_regfile: RTL and testbench



---
 rtl/bus_dest_regfile_pkg.sv | 40 ++++
 rtl/bus_dest_regfile_dest_decoder.sv | 28 ++
 rtl/bus_dest_regfile.sv | 139 +++++++++++++
 tb/tb_bus_dest_regfile.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_dest_regfile_pkg.sv
// Shared datapath definitions: destination codes and load-vector layout
// used by the bus-side encoder, multiplexer and destination register file.
package bus_dest_regfile_pkg;

    localparam logic [4:0] CODE_R0     = 5'd0;
    localparam logic [4:0] CODE_R1     = 5'd1;
    localparam logic [4:0] CODE_R2     = 5'd2;
    localparam logic [4:0] CODE_R3     = 5'd3;
    localparam logic [4:0] CODE_R4     = 5'd4;
    localparam logic [4:0] CODE_R5     = 5'd5;
    localparam logic [4:0] CODE_R6     = 5'd6;
    localparam logic [4:0] CODE_R7     = 5'd7;
    localparam logic [4:0] CODE_R8     = 5'd8;
    localparam logic [4:0] CODE_R9     = 5'd9;
    localparam logic [4:0] CODE_R10    = 5'd10;
    localparam logic [4:0] CODE_R11    = 5'd11;
    localparam logic [4:0] CODE_R12    = 5'd12;
    localparam logic [4:0] CODE_R13    = 5'd13;
    localparam logic [4:0] CODE_R14    = 5'd14;
    localparam logic [4:0] CODE_R15    = 5'd15;
    localparam logic [4:0] CODE_HI     = 5'd16;
    localparam logic [4:0] CODE_LO     = 5'd17;
    localparam logic [4:0] CODE_ZHI    = 5'd18;
    localparam logic [4:0] CODE_ZLO    = 5'd19;
    localparam logic [4:0] CODE_PC     = 5'd20;
    localparam logic [4:0] CODE_MDR    = 5'd21;
    localparam logic [4:0] CODE_INPORT = 5'd22;
    localparam logic [4:0] CODE_CEXT   = 5'd23;

    // Load vector: bits 0..15 are R0..R15, then HI, LO, PC
    localparam int LOAD_W = 19;
    localparam int LD_HI  = 16;
    localparam int LD_LO  = 17;
    localparam int LD_PC  = 18;

    function automatic logic code_is_writable(input logic [4:0] code);
        return (code <= CODE_LO) || (code == CODE_PC);
    endfunction

endpackage

// File: rtl/bus_dest_regfile_dest_decoder.sv
// Combinational destination decoder: (wr_en, wr_code) to a one-hot
// load vector plus an illegal-destination indication.
module dest_decoder
    import bus_dest_regfile_pkg::*;
(
    input  logic              wr_en,
    input  logic [4:0]        wr_code,
    output logic [LOAD_W-1:0] load,
    output logic              illegal
);

    always_comb begin
        load    = '0;
        illegal = 1'b0;
        if (wr_en) begin
            if (!code_is_writable(wr_code)) begin
                illegal = 1'b1;
            end else if (wr_code == CODE_PC) begin
                load[LD_PC] = 1'b1;
            end else begin
                for (int i = 0; i < LD_PC; i++) begin
                    if (wr_code == 5'(i)) load[i] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/bus_dest_regfile.sv
// Destination register file: R0-R15, HI, LO, PC written from the bus,
// with paired Z load, PC increment, sticky illegal-code flag and counter.
module bus_dest_regfile
    import bus_dest_regfile_pkg::*;
#(
    parameter int unsigned PC_STEP = 1,
    parameter int          CNT_W   = 16
) (
    input  logic             clock,
    input  logic             clear_n,
    input  logic [31:0]      bus_in,
    input  logic             wr_en,
    input  logic [4:0]       wr_code,
    input  logic             z_pair_wr,
    input  logic [31:0]      zhigh_in,
    input  logic [31:0]      zlo_in,
    input  logic             pc_inc,
    input  logic             err_clr,
    output logic [31:0]      r0,
    output logic [31:0]      r1,
    output logic [31:0]      r2,
    output logic [31:0]      r3,
    output logic [31:0]      r4,
    output logic [31:0]      r5,
    output logic [31:0]      r6,
    output logic [31:0]      r7,
    output logic [31:0]      r8,
    output logic [31:0]      r9,
    output logic [31:0]      r10,
    output logic [31:0]      r11,
    output logic [31:0]      r12,
    output logic [31:0]      r13,
    output logic [31:0]      r14,
    output logic [31:0]      r15,
    output logic [31:0]      hi_reg,
    output logic [31:0]      lo_reg,
    output logic [31:0]      pc,
    output logic             err_illegal,
    output logic [4:0]       err_code,
    output logic [CNT_W-1:0] wr_count
);

    logic [31:0]       gpr [16];
    logic [LOAD_W-1:0] load;
    logic [LOAD_W-1:0] load_eff;
    logic              illegal;
    logic              committed;

    dest_decoder u_dec (
        .wr_en   (wr_en),
        .wr_code (wr_code),
        .load    (load),
        .illegal (illegal)
    );

    // The Z pair owns HI/LO this cycle; a bus write to them is dropped
    always_comb begin
        load_eff = load;
        if (z_pair_wr) begin
            load_eff[LD_HI] = 1'b0;
            load_eff[LD_LO] = 1'b0;
        end
    end

    assign committed = |load_eff;

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            for (int i = 0; i < 16; i++) gpr[i] <= '0;
        end else begin
            for (int i = 0; i < 16; i++) begin
                if (load_eff[i]) gpr[i] <= bus_in;
            end
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            hi_reg <= '0;
            lo_reg <= '0;
        end else if (z_pair_wr) begin
            hi_reg <= zhigh_in;
            lo_reg <= zlo_in;
        end else begin
            if (load_eff[LD_HI]) hi_reg <= bus_in;
            if (load_eff[LD_LO]) lo_reg <= bus_in;
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            pc <= '0;
        end else if (load_eff[LD_PC]) begin
            pc <= bus_in;
        end else if (pc_inc) begin
            pc <= pc + 32'(PC_STEP);
        end
    end

    // A new illegal write outranks a same-cycle clear
    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            err_illegal <= 1'b0;
            err_code    <= '0;
        end else if (illegal) begin
            err_illegal <= 1'b1;
            if (!err_illegal || err_clr) err_code <= wr_code;
        end else if (err_clr) begin
            err_illegal <= 1'b0;
            err_code    <= '0;
        end
    end

    always_ff @(posedge clock or negedge clear_n) begin
        if (!clear_n) begin
            wr_count <= '0;
        end else if (committed) begin
            wr_count <= wr_count + 1'b1;
        end
    end

    assign r0  = gpr[0];
    assign r1  = gpr[1];
    assign r2  = gpr[2];
    assign r3  = gpr[3];
    assign r4  = gpr[4];
    assign r5  = gpr[5];
    assign r6  = gpr[6];
    assign r7  = gpr[7];
    assign r8  = gpr[8];
    assign r9  = gpr[9];
    assign r10 = gpr[10];
    assign r11 = gpr[11];
    assign r12 = gpr[12];
    assign r13 = gpr[13];
    assign r14 = gpr[14];
    assign r15 = gpr[15];

endmodule

// File: tb/tb_bus_dest_regfile.sv
// Self-checking bench for bus_dest_regfile: reference model compared every
// cycle, plus directed vectors with literal expectations.
module tb_bus_dest_regfile;

    logic        clock = 1'b0;
    logic        clear_n = 1'b0;
    logic [31:0] bus_in = '0;
    logic        wr_en = 1'b0;
    logic [4:0]  wr_code = '0;
    logic        z_pair_wr = 1'b0;
    logic [31:0] zhigh_in = '0;
    logic [31:0] zlo_in = '0;
    logic        pc_inc = 1'b0;
    logic        err_clr = 1'b0;

    logic [31:0] ra [16];
    logic [31:0] hi_a, lo_a, pc_a;
    logic        err_a;
    logic [4:0]  code_a;
    logic [15:0] cnt_a;

    logic [31:0] rb [16];
    logic [31:0] hi_b, lo_b, pc_b;
    logic        err_b;
    logic [4:0]  code_b;
    logic [3:0]  cnt_b;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    bus_dest_regfile dut_a (
        .clock(clock), .clear_n(clear_n), .bus_in(bus_in),
        .wr_en(wr_en), .wr_code(wr_code), .z_pair_wr(z_pair_wr),
        .zhigh_in(zhigh_in), .zlo_in(zlo_in), .pc_inc(pc_inc),
        .err_clr(err_clr),
        .r0(ra[0]), .r1(ra[1]), .r2(ra[2]), .r3(ra[3]),
        .r4(ra[4]), .r5(ra[5]), .r6(ra[6]), .r7(ra[7]),
        .r8(ra[8]), .r9(ra[9]), .r10(ra[10]), .r11(ra[11]),
        .r12(ra[12]), .r13(ra[13]), .r14(ra[14]), .r15(ra[15]),
        .hi_reg(hi_a), .lo_reg(lo_a), .pc(pc_a),
        .err_illegal(err_a), .err_code(code_a), .wr_count(cnt_a)
    );

    bus_dest_regfile #(.CNT_W(4)) dut_b (
        .clock(clock), .clear_n(clear_n), .bus_in(bus_in),
        .wr_en(wr_en), .wr_code(wr_code), .z_pair_wr(z_pair_wr),
        .zhigh_in(zhigh_in), .zlo_in(zlo_in), .pc_inc(pc_inc),
        .err_clr(err_clr),
        .r0(rb[0]), .r1(rb[1]), .r2(rb[2]), .r3(rb[3]),
        .r4(rb[4]), .r5(rb[5]), .r6(rb[6]), .r7(rb[7]),
        .r8(rb[8]), .r9(rb[9]), .r10(rb[10]), .r11(rb[11]),
        .r12(rb[12]), .r13(rb[13]), .r14(rb[14]), .r15(rb[15]),
        .hi_reg(hi_b), .lo_reg(lo_b), .pc(pc_b),
        .err_illegal(err_b), .err_code(code_b), .wr_count(cnt_b)
    );

    // Reference model state
    logic [31:0] m_r [16];
    logic [31:0] m_hi, m_lo, m_pc;
    logic        m_err;
    logic [4:0]  m_code;
    int unsigned m_cnt;
    bit          chk_on = 1'b0;

    task automatic chk(input string n, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h t=%0t", n, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_r[i] = '0;
        m_hi = '0;
        m_lo = '0;
        m_pc = '0;
        m_err = 1'b0;
        m_code = '0;
        m_cnt = 0;
    endtask

    initial model_reset();

    always @(negedge clear_n) model_reset();

    always @(posedge clock) begin
        if (clear_n) begin
            bit legal;
            bit pc_written;
            int c;
            c = int'(wr_code);
            legal = (c <= 17) || (c == 20);
            pc_written = 1'b0;
            if (wr_en && legal) begin
                if (z_pair_wr && (c == 16 || c == 17)) begin
                end else begin
                    m_cnt++;
                    if (c < 16) m_r[c] = bus_in;
                    else if (c == 16) m_hi = bus_in;
                    else if (c == 17) m_lo = bus_in;
                    else begin
                        m_pc = bus_in;
                        pc_written = 1'b1;
                    end
                end
            end
            if (z_pair_wr) begin
                m_hi = zhigh_in;
                m_lo = zlo_in;
            end
            if (pc_inc && !pc_written) m_pc = m_pc + 32'd1;
            if (wr_en && !legal) begin
                if (!m_err || err_clr) m_code = wr_code;
                m_err = 1'b1;
            end else if (err_clr) begin
                m_err = 1'b0;
                m_code = '0;
            end
        end
    end

    always @(negedge clock) begin
        if (chk_on && clear_n) begin
            for (int i = 0; i < 16; i++) begin
                chk($sformatf("r%0d", i), ra[i], m_r[i]);
                chk($sformatf("b_r%0d", i), rb[i], m_r[i]);
            end
            chk("hi", hi_a, m_hi);
            chk("lo", lo_a, m_lo);
            chk("pc", pc_a, m_pc);
            chk("err", 32'(err_a), 32'(m_err));
            chk("code", 32'(code_a), 32'(m_code));
            chk("cnt", 32'(cnt_a), m_cnt & 32'hFFFF);
            chk("b_cnt", 32'(cnt_b), m_cnt & 32'hF);
            chk("b_pc", pc_b, m_pc);
            chk("b_err", 32'(err_b), 32'(m_err));
            chk("b_code", 32'(code_b), 32'(m_code));
            chk("b_hi", hi_b, m_hi);
            chk("b_lo", lo_b, m_lo);
        end
    end

    task automatic cyc(input logic en, input logic [4:0] code,
                       input logic [31:0] bus, input logic zp,
                       input logic inc, input logic clr);
        @(negedge clock);
        wr_en = en;
        wr_code = code;
        bus_in = bus;
        z_pair_wr = zp;
        pc_inc = inc;
        err_clr = clr;
    endtask

    task automatic idle();
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        repeat (3) @(negedge clock);
        #1 clear_n = 1'b1;
        chk_on = 1'b1;
        @(negedge clock);
        chk("rst_r0", ra[0], 32'd0);
        chk("rst_pc", pc_a, 32'd0);
        chk("rst_cnt", 32'(cnt_a), 32'd0);

        for (int k = 0; k < 16; k++)
            cyc(1'b1, 5'(k), 32'hA000_0000 + 32'(k), 1'b0, 1'b0, 1'b0);
        idle();
        chk("lit_r0", ra[0], 32'hA000_0000);
        chk("lit_r5", ra[5], 32'hA000_0005);
        chk("lit_r15", ra[15], 32'hA000_000F);
        chk("lit_cnt16", 32'(cnt_a), 32'd16);
        chk("lit_hi0", hi_a, 32'd0);

        cyc(1'b1, 5'd19, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0);
        idle();
        chk("lit_err", 32'(err_a), 32'd1);
        chk("lit_code19", 32'(code_a), 32'd19);
        chk("lit_cnt_ill", 32'(cnt_a), 32'd16);
        cyc(1'b1, 5'd22, 32'h1234_5678, 1'b0, 1'b0, 1'b0);
        idle();
        chk("lit_code_keep", 32'(code_a), 32'd19);
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1);
        idle();
        chk("lit_clr_err", 32'(err_a), 32'd0);
        chk("lit_clr_code", 32'(code_a), 32'd0);

        cyc(1'b1, 5'd25, 32'd0, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 5'd24, 32'd0, 1'b0, 1'b0, 1'b1);
        idle();
        chk("lit_clr_vs_ill", 32'(code_a), 32'd24);
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 1'b0, 1'b1);

        zhigh_in = 32'h1111_1111;
        zlo_in = 32'h2222_2222;
        cyc(1'b1, 5'd16, 32'h3333_3333, 1'b1, 1'b0, 1'b0);
        idle();
        chk("lit_zhi", hi_a, 32'h1111_1111);
        chk("lit_zlo", lo_a, 32'h2222_2222);
        chk("lit_z_cnt", 32'(cnt_a), 32'd16);
        chk("lit_z_err", 32'(err_a), 32'd0);

        zhigh_in = 32'h4444_4444;
        zlo_in = 32'h5555_5555;
        cyc(1'b1, 5'd7, 32'h7777_7777, 1'b1, 1'b0, 1'b0);
        idle();
        chk("lit_z_par_r7", ra[7], 32'h7777_7777);
        chk("lit_z_par_cnt", 32'(cnt_a), 32'd17);

        cyc(1'b1, 5'd20, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        idle();
        chk("lit_b_cnt1", 32'(cnt_b), 32'd2);
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        idle();
        chk("lit_pc_wrap", pc_a, 32'd0);
        cyc(1'b1, 5'd20, 32'h100, 1'b0, 1'b1, 1'b0);
        idle();
        chk("lit_pc_prio", pc_a, 32'h100);
        cyc(1'b0, 5'd0, 32'd0, 1'b0, 1'b1, 1'b0);
        idle();
        chk("lit_pc_inc", pc_a, 32'h101);

        cyc(1'b0, 5'd31, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b0);
        idle();
        chk("lit_noen_err", 32'(err_a), 32'd0);
        chk("lit_noen_cnt", 32'(cnt_a), 32'd19);

        cyc(1'b1, 5'd5, 32'h5, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 5'd5, 32'h6, 1'b0, 1'b0, 1'b0);
        @(posedge clock);
        #1 chk("lit_r5_b2b", ra[5], 32'h6);
        #1 clear_n = 1'b0;
        wr_en = 1'b0;
        #1;
        for (int i = 0; i < 16; i++)
            chk($sformatf("async_r%0d", i), ra[i], 32'd0);
        chk("async_hi", hi_a, 32'd0);
        chk("async_lo", lo_a, 32'd0);
        chk("async_pc", pc_a, 32'd0);
        chk("async_cnt", 32'(cnt_a), 32'd0);
        chk("async_b_cnt", 32'(cnt_b), 32'd0);
        @(negedge clock);
        #1 clear_n = 1'b1;

        for (int k = 0; k < 17; k++)
            cyc(1'b1, 5'd3, 32'(k), 1'b0, 1'b0, 1'b0);
        idle();
        chk("lit_b_wrap17", 32'(cnt_b), 32'd1);
        chk("lit_a_17", 32'(cnt_a), 32'd17);
        chk("lit_r3_last", ra[3], 32'd16);
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
